// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - N-port round-robin arbiter sharing one registered-output BRAM read port
module bram_rr_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH    = 8,
  localparam int IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            data_req,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            data_rdy,
  output logic [ADDRESS_WIDTH-1:0]        mem_data_addr,
  input  logic [DATA_WIDTH-1:0]           mem_data,
  output logic                            busy,
  output logic [IDX_W-1:0]                grant_idx
);

  // Scan width is one bit wider than the index so ptr+i never overflows before the wrap.
  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_nxt;
  logic [IDX_W-1:0]     winner;
  logic [CW-1:0]        cand;
  logic                 found;
  logic [NUM_PORTS-1:0] eligible;

  // A port whose data is being handed back this cycle must not be re-granted on the same edge.
  assign eligible = data_req & ~data_rdy;

  // Pointer advances past the port just served, wrapping at NUM_PORTS rather than 2^IDX_W.
  assign ptr_nxt = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);

  // First eligible port scanning ptr, ptr+1, ... modulo NUM_PORTS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_PORTS)) begin
        cand = cand - CW'(NUM_PORTS);
      end
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one access is a fixed IDLE -> READ -> RESP walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = found ? READ : IDLE;
      READ:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: latch grant and address in IDLE, deliver BRAM data and rdy pulse out of RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr           <= '0;
      grant_idx     <= '0;
      mem_data_addr <= '0;
      data_out      <= '0;
      data_rdy      <= '0;
    end else begin
      data_rdy <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx     <= winner;
            mem_data_addr <= data_addr[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          end
        end
        RESP: begin
          data_out[grant_idx*DATA_WIDTH +: DATA_WIDTH] <= mem_data;
          data_rdy[grant_idx]                          <= 1'b1;
          ptr                                          <= ptr_nxt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb/tb_bram_rr_arbiter.sv - directed self-checking bench for bram_rr_arbiter
module tb_bram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data_req;
  logic [27:0] data_addr;
  logic [31:0] data_out;
  logic [3:0]  data_rdy;
  logic [6:0]  mem_data_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic [1:0]  grant_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bram [0:127];

  bram_rr_arbiter #(
    .NUM_PORTS(4),
    .ADDRESS_WIDTH(7),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_req(data_req),
    .data_addr(data_addr),
    .data_out(data_out),
    .data_rdy(data_rdy),
    .mem_data_addr(mem_data_addr),
    .mem_data(mem_data),
    .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  // Registered-output BRAM holding 2*i at address i.
  initial begin
    for (int i = 0; i < 128; i++) bram[i] = 8'(2 * i);
  end
  always @(posedge clk) mem_data <= bram[mem_data_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dslice(input int p);
    return data_out[p*8 +: 8];
  endfunction

  task automatic set_addr(input int p, input int a);
    data_addr[p*7 +: 7] = 7'(a);
  endtask

  // Waits (bounded) for the next negedge with any rdy bit set.
  task automatic wait_rdy(output logic [3:0] r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_rdy == 4'b0 && n < 20);
    check("rdy_seen", 32'(data_rdy != 4'b0), 32'd1);
    r = data_rdy;
  endtask

  initial begin
    logic [3:0] r;
    int a [4];
    int reqc [4];
    int cnt [4];
    int order;
    int first;
    int p;

    rst       = 1'b0;
    data_req  = '0;
    data_addr = '0;

    // Reset held with random requests.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_req = 4'($urandom);
      check("rst_rdy", 32'(data_rdy), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out", data_out, 32'd0);
      check("rst_addr", 32'(mem_data_addr), 32'd0);
      check("rst_grant", 32'(grant_idx), 32'd0);
    end
    rst      = 1'b1;
    data_req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rdy", 32'(data_rdy), 32'd0);
    end

    // Single port 2, address 13.
    set_addr(2, 13);
    data_req = 4'b0100;
    @(negedge clk);
    check("single_addr", 32'(mem_data_addr), 32'd13);
    check("single_grant", 32'(grant_idx), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    check("single_rdy_e1", 32'(data_rdy), 32'd0);
    @(negedge clk);
    check("single_rdy_e2", 32'(data_rdy), 32'd0);
    @(negedge clk);
    check("single_rdy_e3", 32'(data_rdy), 32'h4);
    check("single_data", 32'(dslice(2)), 32'd26);
    data_req = 4'b0000;
    @(negedge clk);
    check("single_rdy_done", 32'(data_rdy), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // Pointer wrap: serve port 3, then 0 and 3 together -> 0 wins.
    set_addr(3, 7);
    data_req = 4'b1000;
    wait_rdy(r);
    check("wrap_p3", 32'(r), 32'h8);
    check("wrap_p3_data", 32'(dslice(3)), 32'd14);
    data_req = 4'b0000;
    @(negedge clk);
    set_addr(0, 3);
    data_req = 4'b1001;
    wait_rdy(r);
    check("wrap_first", 32'(r), 32'h1);
    check("wrap_p0_data", 32'(dslice(0)), 32'd6);
    data_req[0] = 1'b0;
    wait_rdy(r);
    check("wrap_second", 32'(r), 32'h8);
    data_req = 4'b0000;
    @(negedge clk);

    // All four ports requesting continuously.
    for (int i = 0; i < 4; i++) begin
      a[i]    = 10 * i;
      reqc[i] = 0;
      set_addr(i, a[i]);
    end
    data_req = 4'b1111;
    order    = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (data_rdy != 4'b0) begin
        check("rr_onehot", 32'($countones(data_rdy)), 32'd1);
        p = 0;
        for (int i = 0; i < 4; i++) if (data_rdy[i]) p = i;
        check("rr_order", p, order % 4);
        check("rr_data", 32'(dslice(p)), 32'(8'(2 * a[p])));
        check("rr_wait", 32'((c - reqc[p]) <= 12), 32'd1);
        a[p]++;
        set_addr(p, a[p]);
        reqc[p] = c;
        order++;
      end
    end
    data_req = 4'b0000;
    check("rr_total", order, 16);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Reset while port 1 is in READ.
    set_addr(1, 5);
    data_req = 4'b0010;
    @(negedge clk);
    check("rstr_busy", 32'(busy), 32'd1);
    check("rstr_grant", 32'(grant_idx), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rstr_rdy", 32'(data_rdy), 32'd0);
    check("rstr_out", data_out, 32'd0);
    check("rstr_idle", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_rdy(r);
    check("rstr_again", 32'(r), 32'h2);
    check("rstr_data", 32'(dslice(1)), 32'd10);
    data_req = 4'b0000;
    @(negedge clk);

    // Port 2 withdraws during READ while port 3 waits.
    set_addr(2, 40);
    set_addr(3, 50);
    data_req = 4'b1100;
    @(negedge clk);
    check("wd_grant", 32'(grant_idx), 32'd2);
    data_req[2] = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (data_rdy[i]) begin
          cnt[i]++;
          if (first < 0) first = i;
        end
      end
      if (data_rdy[3]) data_req[3] = 1'b0;
    end
    check("wd_first", first, 2);
    check("wd_cnt2", cnt[2], 1);
    check("wd_cnt3", cnt[3], 1);
    check("wd_data2", 32'(dslice(2)), 32'd80);
    check("wd_data3", 32'(dslice(3)), 32'd100);
    check("wd_keep1", 32'(dslice(1)), 32'd10);
    check("wd_keep0", 32'(dslice(0)), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
